// File: rtl/calc_fnd_if.sv
// Handshake and display bus between board-side logic and the calc_fnd_ctrl core.
interface calc_fnd_if #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 4
) ();
   logic [WIDTH-1:0]  a;
   logic [WIDTH-1:0]  b;
   logic [1:0]        op;
   logic              start;
   logic              busy;
   logic              done;
   logic              overflow;
   logic [7:0]        fnd_data;
   logic [DIGITS-1:0] fnd_com;

   modport master (
      output a, b, op, start,
      input  busy, done, overflow, fnd_data, fnd_com
   );

   modport slave (
      input  a, b, op, start,
      output busy, done, overflow, fnd_data, fnd_com
   );
endinterface

// File: rtl/calc_fnd_ctrl.sv
// Calculator core: add/sub/mul, iterative double-dabble BCD conversion and a scanned FND driver.
// Define CALC_FND_SIGN_EN to show a<b subtraction as a negative magnitude with a minus digit.
module calc_fnd_ctrl #(
   parameter int WIDTH    = 8,
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 100000
) (
   input  logic      clk,
   input  logic      reset,
   calc_fnd_if.slave bus
);
   localparam int RES_W = 2 * WIDTH;
   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int BIT_W = (RES_W > 1) ? $clog2(RES_W) : 1;

   typedef enum logic [1:0] {IDLE, CALC, CONV, DONE} state_t;

   state_t            state, next_state;
   logic [BIT_W-1:0]  bit_cnt;
   logic              busy_c, done_c;

   logic [WIDTH-1:0]  a_q, b_q;
   logic [1:0]        op_q;
   logic [WIDTH-1:0]  diff_ab;
   logic [RES_W-1:0]  calc_mag;
   logic              calc_neg;
   logic [RES_W-1:0]  mag_sr;
   logic [BCD_W-1:0]  bcd, bcd_adj;
   logic              carry, sign_q, res_ovf;

   logic [BCD_W-1:0]  disp_bcd;
   logic              disp_sign, disp_ovf;
   logic [CNT_W-1:0]  scan_cnt;
   logic [IDX_W-1:0]  idx, msd;
   logic [3:0]        nib;
   logic [7:0]        seg;

   function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] v);
      logic [BCD_W-1:0] r;
      r = v;
      for (int i = 0; i < DIGITS; i++)
         if (v[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = v[i*4 +: 4] + 4'd3;
      return r;
   endfunction

   function automatic logic [7:0] seg_code(input logic [3:0] d);
      case (d)
         4'd0:    return 8'hC0;
         4'd1:    return 8'hF9;
         4'd2:    return 8'hA4;
         4'd3:    return 8'hB0;
         4'd4:    return 8'h99;
         4'd5:    return 8'h92;
         4'd6:    return 8'h82;
         4'd7:    return 8'hF8;
         4'd8:    return 8'h80;
         4'd9:    return 8'h90;
         default: return 8'hFF;
      endcase
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      busy_c     = 1'b0;
      done_c     = 1'b0;
      case (state)
         IDLE: if (bus.start) next_state = CALC;
         CALC: begin
            busy_c     = 1'b1;
            next_state = CONV;
         end
         CONV: begin
            busy_c = 1'b1;
            if (bit_cnt == BIT_W'(RES_W - 1)) next_state = DONE;
         end
         DONE: begin
            busy_c     = 1'b1;
            done_c     = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)              bit_cnt <= '0;
      else if (state == CALC)  bit_cnt <= '0;
      else if (state == CONV)  bit_cnt <= bit_cnt + 1'b1;
   end

   // Arithmetic on the latched operands; only consumed in CALC
   assign diff_ab = a_q - b_q;

`ifdef CALC_FND_SIGN_EN
   logic [WIDTH-1:0] diff_ba;
   assign diff_ba = b_q - a_q;
`endif

   always_comb begin
      calc_mag = RES_W'(a_q) + RES_W'(b_q);
      calc_neg = 1'b0;
      case (op_q)
         2'b01: begin
`ifdef CALC_FND_SIGN_EN
            if (a_q < b_q) begin
               calc_mag = {{WIDTH{1'b0}}, diff_ba};
               calc_neg = 1'b1;
            end else begin
               calc_mag = {{WIDTH{1'b0}}, diff_ab};
            end
`else
            calc_mag = {{WIDTH{1'b0}}, diff_ab};
`endif
         end
         2'b10:   calc_mag = RES_W'(a_q) * RES_W'(b_q);
         default: calc_mag = RES_W'(a_q) + RES_W'(b_q);
      endcase
   end

   assign bcd_adj = dd_adjust(bcd);

   // Datapath registers carry no reset: IDLE never consumes them
   always_ff @(posedge clk) begin
      case (state)
         IDLE: if (bus.start) begin
            a_q  <= bus.a;
            b_q  <= bus.b;
            op_q <= bus.op;
         end
         CALC: begin
            mag_sr <= calc_mag;
            sign_q <= calc_neg;
            bcd    <= '0;
            carry  <= 1'b0;
         end
         CONV: begin
            carry  <= carry | bcd_adj[BCD_W-1];
            bcd    <= {bcd_adj[BCD_W-2:0], mag_sr[RES_W-1]};
            mag_sr <= mag_sr << 1;
         end
         default: ;
      endcase
   end

   // A negative result must leave the top digit free for the minus sign
   assign res_ovf = carry | (sign_q & (bcd[BCD_W-1 -: 4] != 4'd0));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         disp_bcd  <= '0;
         disp_sign <= 1'b0;
         disp_ovf  <= 1'b0;
      end else if (state == DONE) begin
         disp_bcd  <= bcd;
         disp_sign <= sign_q;
         disp_ovf  <= res_ovf;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scan_cnt <= '0;
         idx      <= '0;
      end else if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
         scan_cnt <= '0;
         idx      <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   // msd is the most significant non-zero digit; everything above it is blanked
   always_comb begin
      msd = '0;
      nib = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (disp_bcd[i*4 +: 4] != 4'd0) msd = IDX_W'(i);
         if (IDX_W'(i) == idx)           nib = disp_bcd[i*4 +: 4];
      end
      seg = seg_code(nib);
      if (idx > msd)                                   seg = 8'hFF;
      if (disp_sign && (idx == IDX_W'(DIGITS - 1)))    seg = 8'hBF;
      if (disp_ovf)                                    seg = 8'hBF;
   end

   assign bus.busy     = busy_c;
   assign bus.done     = done_c;
   assign bus.overflow = disp_ovf;
   assign bus.fnd_data = seg;
   assign bus.fnd_com  = ~(DIGITS'(1) << idx);
endmodule

// File: tb/tb_calc_fnd_ctrl.sv
// Self-checking bench for calc_fnd_ctrl: vector table, handshake corner cases, random and sweep runs.
`timescale 1ns/1ps
module tb_calc_fnd_ctrl;
   localparam int WIDTH    = 8;
   localparam int DIGITS   = 4;
   localparam int SCAN_DIV = 4;
   localparam int RES_W    = 2 * WIDTH;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   calc_fnd_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

   calc_fnd_ctrl #(.WIDTH(WIDTH), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   typedef struct {
      int          a;
      int          b;
      int          op;
      logic [31:0] segs;
      logic        ovf;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Decimal reference: returns {overflow, digit3..digit0 segment codes}
   function automatic logic [32:0] model(input int a, input int b, input int op);
      int   mag, p;
      bit   neg, ovf;
      logic [31:0] s;
      neg = 0;
      case (op)
         1: begin
`ifdef CALC_FND_SIGN_EN
            if (a < b) begin neg = 1; mag = b - a; end
            else mag = a - b;
`else
            mag = (a - b + 256) % 256;
`endif
         end
         2:       mag = a * b;
         default: mag = a + b;
      endcase
      ovf = neg ? (mag > 999) : (mag > 9999);
      p = 1;
      for (int i = 0; i < DIGITS; i++) begin
         if (ovf)                        s[i*8 +: 8] = 8'hBF;
         else if (neg && i == DIGITS-1)  s[i*8 +: 8] = 8'hBF;
         else if (i > 0 && mag < p)      s[i*8 +: 8] = 8'hFF;
         else                            s[i*8 +: 8] = seg_tab[(mag / p) % 10];
         p = p * 10;
      end
      return {ovf, s};
   endfunction

   task automatic read_disp(output logic [31:0] segs);
      logic [3:0] sel;
      segs = '0;
      for (int c = 0; c < DIGITS * SCAN_DIV + 2; c++) begin
         @(posedge clk); #1;
         for (int i = 0; i < DIGITS; i++) begin
            sel = 4'b0001 << i;
            if (bus.fnd_com == ~sel) segs[i*8 +: 8] = bus.fnd_data;
         end
      end
   endtask

   task automatic run_op(input int a, input int b, input int op);
      int lat;
      @(negedge clk);
      bus.a = WIDTH'(a); bus.b = WIDTH'(b); bus.op = 2'(op); bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("busy_after_start", {31'd0, bus.busy}, 32'd1);
      lat = -1;
      for (int k = 1; k <= 100 && lat < 0; k++) begin
         @(posedge clk); #1;
         if (bus.done) lat = k;
      end
      check("done_latency", lat, RES_W + 1);
      @(posedge clk); #1;
      check("done_pulse_end", {30'd0, bus.done, bus.busy}, 32'd0);
   endtask

   task automatic apply_check(input string name, input int a, input int b, input int op,
                              input logic [31:0] exp_segs, input logic exp_ovf);
      logic [31:0] segs;
      run_op(a, b, op);
      read_disp(segs);
      check({name, "_segs"}, segs, exp_segs);
      check({name, "_ovf"}, {31'd0, bus.overflow}, {31'd0, exp_ovf});
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish within time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [32:0] m;
      logic [31:0] segs;
      logic [3:0]  exp_com;
      int          ndone, idx, ra, rb, rop;

      bus.a = '0; bus.b = '0; bus.op = '0; bus.start = 1'b0;

      vecs.push_back('{25,  17,  0, 32'hFFFF99A4, 1'b0});
      vecs.push_back('{99,  99,  2, 32'h9080C0F9, 1'b0});
      vecs.push_back('{200, 100, 2, 32'hBFBFBFBF, 1'b1});
`ifdef CALC_FND_SIGN_EN
      vecs.push_back('{5,   9,   1, 32'hBFFFFF99, 1'b0});
      vecs.push_back('{0,   255, 1, 32'hBFA49292, 1'b0});
`else
      vecs.push_back('{5,   9,   1, 32'hFFA492A4, 1'b0});
      vecs.push_back('{0,   255, 1, 32'hFFFFFFF9, 1'b0});
`endif
      vecs.push_back('{0,   0,   0, 32'hFFFFFFC0, 1'b0});
      vecs.push_back('{255, 255, 0, 32'hFF92F9C0, 1'b0});
      vecs.push_back('{99,  101, 2, 32'h90909090, 1'b0});
      vecs.push_back('{100, 100, 2, 32'hBFBFBFBF, 1'b1});
      vecs.push_back('{9,   5,   1, 32'hFFFFFF99, 1'b0});
      vecs.push_back('{3,   4,   3, 32'hFFFFFFF8, 1'b0});
      vecs.push_back('{255, 255, 2, 32'hBFBFBFBF, 1'b1});
      vecs.push_back('{10,  100, 2, 32'hF9C0C0C0, 1'b0});

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_done", {31'd0, bus.done}, 32'd0);
      check("rst_ovf", {31'd0, bus.overflow}, 32'd0);
      check("rst_com", {28'd0, bus.fnd_com}, 32'b1110);
      check("rst_data", {24'd0, bus.fnd_data}, 32'hC0);

      // Scan sequence after release
      @(negedge clk);
      reset = 1'b1;
      #1;
      for (int p = 0; p <= 16; p++) begin
         if (p > 0) begin @(posedge clk); #1; end
         idx = (p / SCAN_DIV) % DIGITS;
         exp_com = ~(4'b0001 << idx);
         check("scan_com", {28'd0, bus.fnd_com}, {28'd0, exp_com});
         check("scan_data", {24'd0, bus.fnd_data}, (idx == 0) ? 32'hC0 : 32'hFF);
      end

      // Table vectors
      for (int v = 0; v < vecs.size(); v++)
         apply_check($sformatf("vec%0d", v), vecs[v].a, vecs[v].b, vecs[v].op,
                     vecs[v].segs, vecs[v].ovf);

      // Second start and operand change while busy
      @(negedge clk);
      bus.a = 8'd25; bus.b = 8'd17; bus.op = 2'd0; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      ndone = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 3 || k == 10) begin
            bus.a = 8'd99; bus.b = 8'd99; bus.op = 2'd2; bus.start = 1'b1;
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clk); #1;
         if (bus.done) ndone++;
      end
      check("abuse_done_count", ndone, 1);
      m = model(25, 17, 0);
      read_disp(segs);
      check("abuse_segs", segs, m[31:0]);

      // Reset in the middle of conversion
      @(negedge clk);
      bus.a = 8'd123; bus.b = 8'd45; bus.op = 2'd2; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (8) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      check("midrst_busy", {31'd0, bus.busy}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      ndone = 0;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk); #1;
         if (bus.done) ndone++;
      end
      check("midrst_no_done", ndone, 0);
      read_disp(segs);
      check("midrst_segs", segs, 32'hFFFFFFC0);
      check("midrst_ovf", {31'd0, bus.overflow}, 32'd0);

      // Random operations against the reference model
      for (int r = 0; r < 40; r++) begin
         ra  = $urandom_range(0, 255);
         rb  = $urandom_range(0, 255);
         rop = $urandom_range(0, 3);
         m = model(ra, rb, rop);
         apply_check("rand", ra, rb, rop, m[31:0], m[32]);
      end

      // Add sweep over 0..110
      for (int sa = 0; sa <= 110; sa += 5)
         for (int sb = 0; sb <= 110; sb += 5) begin
            m = model(sa, sb, 0);
            apply_check("sweep", sa, sb, 0, m[31:0], 1'b0);
         end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/calc_fnd_ctrl.md
# calc_fnd_ctrl

Parametrised calculator core with a registered start/done handshake, an iterative binary-to-BCD converter and a multiplexed 7-segment (FND) scan driver. It generalises the fixed 8-bit adder-to-FND calculator to configurable operand width and digit count, and adds add/sub/mul modes, overflow indication, leading-zero blanking and an optional signed display. It sits between the board switch/button logic and the FND pins.

## Interface
- WIDTH, 8, operand width in bits; result width RES_W = 2*WIDTH
- DIGITS, 4, number of FND digits (1..8)
- SCAN_DIV, 100000, clk cycles per digit in the scan
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- op  input  2  00 add, 01 sub, 10 mul, 11 reserved (treated as add)
- start  input  1  request; sampled only in IDLE
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse when the display register updates
- overflow  output  1  last result not representable on DIGITS digits
- fnd_data  output  8  segments {dp,g,f,e,d,c,b,a}, active-low
- fnd_com  output  DIGITS  digit enables, active-low, one-hot

## Operation
- FSM: IDLE -> CALC -> CONV -> DONE -> IDLE.
- IDLE: on start=1, latch a, b and op; go to CALC. start in any other state is ignored.
- CALC (1 cycle): compute a+b, a-b or a*b into an RES_W-bit magnitude register.
- CONV (RES_W cycles): shift-add-3 double dabble, one bit per cycle, into DIGITS BCD nibbles plus a carry-out detector.
- DONE (1 cycle): copy BCD, sign and overflow into the display register; done=1.
- Overflow when magnitude > 10^DIGITS-1 (unsigned) or > 10^(DIGITS-1)-1 (negative, sign enabled). Display then shows minus (BF) on every digit.
- Display: digit 0 is rightmost. Leading zeros are blanked (FF). Digit 0 always shows a value.
- Segment codes: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, blank FF, minus BF. dp is always 1.
- Scan: a counter 0..SCAN_DIV-1. On wrap, the digit index advances 0..DIGITS-1 and wraps to 0. fnd_com = ~(1<<index).
- fnd_data and fnd_com are combinational from the index and the display register.

## Timing
- Reset values: busy 0, done 0, overflow 0, FSM IDLE, display register 0 (shows "0"), scan counter 0, index 0, fnd_com = ~1, fnd_data = C0.
- Latency: start sampled at edge N; busy=1 from N+1; done=1 in cycle N+RES_W+2; busy=0 and a new start is accepted from N+RES_W+3.
- Operand changes after the start edge have no effect on the current result.
- The display holds the previous result until done; the scan never stalls during computation.
- Asserting reset mid-operation returns to IDLE immediately and clears the display to "0". The partial result is discarded.
- Sub without a sign: wraps modulo 2^WIDTH and is zero-extended.

## Configuration
- CALC_FND_SIGN_EN defined: sub with a<b produces magnitude b-a with the sign flag set. Digit DIGITS-1 shows minus (BF); the remaining DIGITS-1 digits show the magnitude.
- CALC_FND_SIGN_EN undefined: no sign flag; every result is unsigned; sub uses the wrap rule above.

## Test plan
- Reset: hold reset=0 -> busy=0, done=0, overflow=0, fnd_com=1110, fnd_data=C0; release and run 4 scan periods (SCAN_DIV=4) -> fnd_com cycles 1110,1101,1011,0111,1110 with fnd_data C0,FF,FF,FF.
- Add: a=25, b=17, op=00, start at edge N -> done exactly at N+18. Digits 0..3 = A4, 99, FF, FF; overflow=0.
- Mul, both boundaries:
  - 99*99 -> digits 0..3 = F9, C0, 80, 90 (9801), overflow=0.
  - 200*100 -> overflow=1, all digits BF.
- Sub 5-9:
  - With CALC_FND_SIGN_EN -> digits 0..3 = 99, FF, FF, BF.
  - Without it -> 252: digits 0..2 = A4, 92, A4, digit 3 FF.
- Handshake abuse: second start pulse and operand change while busy -> ignored, result of the first request shown, single done pulse. Reset pulled low mid-CONV -> busy=0 next edge, no done, display "0".
- Sweep: a,b each 0..110, op=add, start/wait done -> every displayed value equals a+b, overflow never set.
